load_store_unit: RTL and testbench

- Initiator side of the unified byte-addressed data memory port.
- Accepts one RISC-V load/store request from the execute stage and translates funct3 into the memory's mode encoding.
- Drives MemRead/MemWrite-style strobes and splits misaligned accesses into byte beats.
- Assembles and sign-extends load data, then returns a one-cycle response pulse with an error flag.

---
 rtl/lsu_pkg.sv | 74 +++++++
 rtl/lsu_byte_assembler.sv | 48 ++++
 rtl/load_store_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// funct3 and memory-mode constants, FSM state type and the size decode helpers.
// LSU_MISALIGN_TRAP_EN removes the SPLIT state from the state type.
package lsu_pkg;

  // RISC-V funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Data memory mode encodings
  localparam logic [2:0] MODE_W  = 3'b000;
  localparam logic [2:0] MODE_HU = 3'b001;
  localparam logic [2:0] MODE_BU = 3'b010;
  localparam logic [2:0] MODE_HS = 3'b011;
  localparam logic [2:0] MODE_BS = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
`ifndef LSU_MISALIGN_TRAP_EN
    , ST_SPLIT
`endif
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } lsu_size_e;

  function automatic lsu_size_e decode_size(input logic [2:0] f3);
    return lsu_size_e'(f3[1:0]);
  endfunction

  // Access width in bytes; zero for the illegal size so the range check stays benign
  function automatic logic [2:0] size_bytes(input lsu_size_e sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Translate a single aligned access into the memory's mode encoding
  function automatic logic [2:0] mem_mode_of(input logic we, input logic [2:0] f3);
    if (we) begin
      case (f3)
        F3_SB:   return MODE_BU;
        F3_SH:   return MODE_HU;
        F3_SW:   return MODE_W;
        default: return MODE_W;
      endcase
    end else begin
      case (f3)
        F3_LB:   return MODE_BS;
        F3_LBU:  return MODE_BU;
        F3_LH:   return MODE_HS;
        F3_LHU:  return MODE_HU;
        F3_LW:   return MODE_W;
        default: return MODE_W;
      endcase
    end
  endfunction

endpackage

// File: rtl/lsu_byte_assembler.sv
// lsu_byte_assembler: load-data lane register plus final sign/zero extension.
// A whole word is captured for single accesses, one byte lane per beat for split ones.
// o_data is the extended value including this cycle's capture, so the parent can
// register the response on the same edge that closes the last memory cycle.
module lsu_byte_assembler
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cap_word,
  input  logic        i_cap_byte,
  input  logic [1:0]  i_lane,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [31:0] r_lanes;
  logic [31:0] w_lanes_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lanes_next[8*gi +: 8] =
        i_cap_word                               ? i_rdata[8*gi +: 8] :
        (i_cap_byte && (i_lane == 2'(gi)))       ? i_rdata[7:0]       :
                                                   r_lanes[8*gi +: 8];
    end
  endgenerate

  // Hold the captured lanes between beats
  always_ff @(posedge clk) begin
    if (!rst) r_lanes <= '0;
    else      r_lanes <= w_lanes_next;
  end

  // Extend the assembled value to 32 bits by access size and signedness
  always_comb begin
    o_data = w_lanes_next;
    case (i_size)
      SZ_B:    o_data = {{24{~i_unsigned & w_lanes_next[7]}},  w_lanes_next[7:0]};
      SZ_H:    o_data = {{16{~i_unsigned & w_lanes_next[15]}}, w_lanes_next[15:0]};
      default: o_data = w_lanes_next;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the byte-addressed data memory port.
// Decodes one load/store, checks legality and range, issues one aligned access
// or a sequence of byte beats, and returns a one-cycle response.
// Build option LSU_MISALIGN_TRAP_EN: misaligned halves/words are errors and
// the byte-beat SPLIT path is not built.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_LIMIT = 4096,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        r_state;
  logic              r_we;
  logic [2:0]        r_f3;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [2:0]        r_mem_mode;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  // Request decode, evaluated against the live request while IDLE
  lsu_size_e         w_req_size;
  logic              w_req_illegal;
  logic [ADDR_W:0]   w_req_end;
  logic              w_req_oob;
  logic              w_req_misaligned;
  logic              w_req_err;
  logic [2:0]        w_req_mode;

  assign w_req_size       = decode_size(req_funct3);
  assign w_req_illegal    = (req_funct3[1:0] == 2'b11)
                          | (~req_we & (req_funct3 == 3'b110))
                          | (req_we & req_funct3[2]);
  // One extra bit so an address near the top of the space cannot wrap past the limit
  assign w_req_end        = {1'b0, req_addr} + (ADDR_W+1)'(size_bytes(w_req_size));
  assign w_req_oob        = w_req_end > (ADDR_W+1)'(ADDR_LIMIT);
  assign w_req_misaligned = ((w_req_size == SZ_H) & req_addr[0])
                          | ((w_req_size == SZ_W) & (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_req_err        = w_req_illegal | w_req_oob | w_req_misaligned;
`else
  assign w_req_err        = w_req_illegal | w_req_oob;
`endif
  assign w_req_mode       = mem_mode_of(req_we, req_funct3);

  lsu_size_e   w_size;
  logic        w_cap_word;
  logic        w_cap_byte;
  logic [1:0]  w_lane;
  logic [31:0] w_asm_data;

  assign w_size     = decode_size(r_f3);
  assign w_cap_word = (r_state == ST_ACCESS) & ~r_we;

`ifndef LSU_MISALIGN_TRAP_EN
  // Byte-beat bookkeeping for split accesses
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_beat;
  logic [1:0]        w_beat_next;
  logic [1:0]        w_last_beat;
  logic              w_split_done;
  logic [ADDR_W-1:0] w_beat_addr_next;
  logic [7:0]        w_beat_byte_next;

  assign w_beat_next      = r_beat + 2'd1;
  assign w_last_beat      = (w_size == SZ_H) ? 2'd1 : 2'd3;
  assign w_split_done     = (r_beat == w_last_beat);
  assign w_beat_addr_next = r_addr + ADDR_W'(w_beat_next);
  assign w_beat_byte_next = r_wdata[{w_beat_next, 3'b000} +: 8];
  assign w_cap_byte       = (r_state == ST_SPLIT) & ~r_we;
  assign w_lane           = r_beat;
`else
  assign w_cap_byte       = 1'b0;
  assign w_lane           = 2'b00;
`endif

  lsu_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .i_cap_word (w_cap_word),
    .i_cap_byte (w_cap_byte),
    .i_lane     (w_lane),
    .i_size     (w_size),
    .i_unsigned (r_f3[2]),
    .i_rdata    (mem_rdata),
    .o_data     (w_asm_data)
  );

  // Control FSM; every memory and response output is registered here
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_f3        <= 3'b000;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_mode  <= MODE_W;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifndef LSU_MISALIGN_TRAP_EN
      r_addr      <= '0;
      r_wdata     <= '0;
      r_beat      <= 2'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (req_valid) begin
            r_we <= req_we;
            r_f3 <= req_funct3;
`ifndef LSU_MISALIGN_TRAP_EN
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_beat  <= 2'd0;
`endif
            if (w_req_err) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_mem_read  <= ~req_we;
              r_mem_write <= req_we;
              r_mem_addr  <= req_addr;
`ifndef LSU_MISALIGN_TRAP_EN
              if (w_req_misaligned) begin
                r_state     <= ST_SPLIT;
                r_mem_mode  <= MODE_BU;
                r_mem_wdata <= {24'b0, req_wdata[7:0]};
              end else
`endif
              begin
                r_state     <= ST_ACCESS;
                r_mem_mode  <= w_req_mode;
                r_mem_wdata <= req_wdata;
              end
            end
          end
        end

        ST_ACCESS: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_mem_mode  <= MODE_W;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= r_we ? 32'd0 : w_asm_data;
        end

`ifndef LSU_MISALIGN_TRAP_EN
        ST_SPLIT: begin
          if (w_split_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_mode  <= MODE_W;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_we ? 32'd0 : w_asm_data;
          end else begin
            r_beat      <= w_beat_next;
            r_mem_addr  <= w_beat_addr_next;
            r_mem_wdata <= {24'b0, w_beat_byte_next};
          end
        end
`endif

        ST_RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_state     <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_mode  = r_mem_mode;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store traffic against a
// behavioural model (byte array plus the access rules), with a bench-side memory.
// Honours LSU_MISALIGN_TRAP_EN for the expected error/latency behaviour.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_LIMIT(4096), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_mode   (mem_mode),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];

  function automatic logic [7:0] init_byte(int i);
    case (i)
      32'h100: return 8'h80;
      32'h101: return 8'h7F;
      32'h102: return 8'h01;
      32'h103: return 8'hFE;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // Bench data memory: writes land mid-cycle on the falling edge
  initial begin
    logic [11:0] a;
    for (int i = 0; i < 4096; i++) mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (mem_write) begin
        a = mem_addr[11:0];
        case (mem_mode)
          3'b000: begin
            mem[a] = mem_wdata[7:0];        mem[a + 12'd1] = mem_wdata[15:8];
            mem[a + 12'd2] = mem_wdata[23:16]; mem[a + 12'd3] = mem_wdata[31:24];
          end
          3'b001: begin
            mem[a] = mem_wdata[7:0];        mem[a + 12'd1] = mem_wdata[15:8];
          end
          3'b010:  mem[a] = mem_wdata[7:0];
          default: ;
        endcase
      end
    end
  end

  logic [7:0] rb0, rb1, rb2, rb3;
  // Combinational memory read by address and mode
  always_comb begin
    rb0 = mem[mem_addr[11:0]];
    rb1 = mem[mem_addr[11:0] + 12'd1];
    rb2 = mem[mem_addr[11:0] + 12'd2];
    rb3 = mem[mem_addr[11:0] + 12'd3];
    case (mem_mode)
      3'b000:  mem_rdata = {rb3, rb2, rb1, rb0};
      3'b001:  mem_rdata = {16'b0, rb1, rb0};
      3'b010:  mem_rdata = {24'b0, rb0};
      3'b011:  mem_rdata = {{16{rb1[7]}}, rb1, rb0};
      3'b100:  mem_rdata = {{24{rb0[7]}}, rb0};
      default: mem_rdata = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_of(logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] exp_mode_of(logic we, logic [2:0] f3);
    if (we) return (f3[1:0] == 2'b00) ? 3'b010 : (f3[1:0] == 2'b01) ? 3'b001 : 3'b000;
    case (f3)
      3'b000:  return 3'b100;
      3'b100:  return 3'b010;
      3'b001:  return 3'b011;
      3'b101:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // One transaction: drive, observe strobes and response, compare with the model
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got_rdata,
                         output logic got_err);
    int sz, lat, nstr, cyc, nr, nw, b;
    bit illegal, oob, mis, err, got_rsp;
    logic [31:0] exp_rdata;
    sz      = size_of(f3);
    illegal = (sz == 0) || (!we && f3 == 3'b110) || (we && f3[2]);
    oob     = (longint'(addr) + longint'(sz)) > 64'd4096;
    mis     = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
    err     = illegal || oob || (TRAP && mis);
    lat     = err ? 1 : (!mis ? 2 : (sz == 2 ? 3 : 5));
    nstr    = err ? 0 : (!mis ? 1 : sz);
    exp_rdata = 32'd0;
    if (!we && !err) begin
      for (int k = 0; k < sz; k++) exp_rdata[8*k +: 8] = ref_mem[(addr[11:0] + 12'(k))];
      if (!f3[2] && sz == 1) exp_rdata = {{24{exp_rdata[7]}}, exp_rdata[7:0]};
      if (!f3[2] && sz == 2) exp_rdata = {{16{exp_rdata[15]}}, exp_rdata[15:0]};
    end

    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    cyc = 0; nr = 0; nw = 0; got_rsp = 1'b0; got_rdata = 32'd0; got_err = 1'b0;
    while (cyc < 20) begin
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
      if (mem_read || mem_write) begin
        b = nr + nw;
        if (mis) begin
          check("beat_addr", mem_addr, addr + 32'(b));
          check("beat_mode", {29'b0, mem_mode}, 32'd2);
          if (we) check("beat_wdata", mem_wdata, {24'b0, wdata[8*b +: 8]});
        end else begin
          check("acc_addr", mem_addr, addr);
          check("acc_mode", {29'b0, mem_mode}, {29'b0, exp_mode_of(we, f3)});
        end
      end
      if (mem_read)  nr++;
      if (mem_write) nw++;
      if (rsp_valid) begin
        got_rsp = 1'b1; got_rdata = rsp_rdata; got_err = rsp_err;
        break;
      end
    end
    if (!got_rsp) check("rsp_timeout", 32'd0, 32'd1);
    check("latency", cyc, lat);
    check("n_reads",  nr, we ? 0 : nstr);
    check("n_writes", nw, we ? nstr : 0);
    check("rsp_err", {31'b0, got_err}, {31'b0, err});
    check("rsp_rdata", got_rdata, exp_rdata);
    @(negedge clk);
    check("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
    if (we && !err) begin
      for (int k = 0; k < sz; k++) begin
        ref_mem[addr[11:0] + 12'(k)] = wdata[8*k +: 8];
        check("store_mem", {24'b0, mem[addr[11:0] + 12'(k)]}, {24'b0, ref_mem[addr[11:0] + 12'(k)]});
      end
    end
    $display("txn we=%0d f3=%0d addr=0x%08h wdata=0x%08h lat=%0d err=%0d rdata=0x%08h",
             we, f3, addr, wdata, cyc, got_err, got_rdata);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    logic [31:0] a, wd, rst_addr, rst_data;
    logic [2:0]  f3;
    logic        we;
    int          nskip, nbytes;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_mem_mode", {29'b0, mem_mode}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Directed cases from the preloaded bytes 80,7F,01,FE at 0x100
    run_req(1'b0, 3'b010, 32'h100, 32'd0, rd, er); check("lw_100", rd, 32'hFE017F80);
    run_req(1'b0, 3'b000, 32'h100, 32'd0, rd, er); check("lb_100", rd, 32'hFFFFFF80);
    run_req(1'b0, 3'b100, 32'h100, 32'd0, rd, er); check("lbu_100", rd, 32'h00000080);
    run_req(1'b0, 3'b001, 32'h102, 32'd0, rd, er); check("lh_102", rd, 32'hFFFFFE01);
    run_req(1'b0, 3'b001, 32'h101, 32'd0, rd, er);
    check("lh_101", rd, TRAP ? 32'd0 : 32'h0000017F);
    run_req(1'b1, 3'b010, 32'h203, 32'hDEADBEEF, rd, er);
    if (!TRAP) check("sw_203_mem", {mem[12'h206], mem[12'h205], mem[12'h204], mem[12'h203]}, 32'hDEADBEEF);
    run_req(1'b0, 3'b011, 32'h100, 32'd0, rd, er); check("f3_011_err", {31'b0, er}, 32'd1);
    run_req(1'b0, 3'b010, 32'hFFE, 32'd0, rd, er); check("lw_ffe_err", {31'b0, er}, 32'd1);
    run_req(1'b0, 3'b010, 32'hFFC, 32'd0, rd, er); check("lw_ffc_ok", {31'b0, er}, 32'd0);
    run_req(1'b0, 3'b100, 32'hFFF, 32'd0, rd, er); check("lbu_fff_ok", {31'b0, er}, 32'd0);
    run_req(1'b1, 3'b100, 32'h300, 32'h12345678, rd, er); check("sbu_err", {31'b0, er}, 32'd1);

    // Random traffic away from the preloaded bytes
    for (int t = 0; t < 80; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1:    a = 32'h400 + 32'($urandom_range(0, 63));
        2:       a = 32'hFF0 + 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      wd = $urandom;
      run_req(we, f3, a, wd, rd, er);
    end

    // Reset in the middle of a store: no response, already-written bytes remain
    rst_addr = TRAP ? 32'h200 : 32'h203;
    rst_data = 32'h11223344;
    nskip    = TRAP ? 0 : 2;
    nbytes   = TRAP ? 4 : 3;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = rst_addr; req_wdata = rst_data;
    @(posedge clk);
    repeat (nskip) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_strobe_before", {31'b0, mem_write}, 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_strobes", {30'b0, mem_read, mem_write}, 32'd0);
      check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < nbytes; k++) ref_mem[rst_addr[11:0] + 12'(k)] = rst_data[8*k +: 8];
    for (int k = 0; k < 4; k++)
      check("abort_mem", {24'b0, mem[rst_addr[11:0] + 12'(k)]}, {24'b0, ref_mem[rst_addr[11:0] + 12'(k)]});
    @(negedge clk);
    check("abort_no_rsp_after", {31'b0, rsp_valid}, 32'd0);
    run_req(1'b0, 3'b010, 32'h100, 32'd0, rd, er); check("lw_after_abort", rd, 32'hFE017F80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
